// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states
// and the access legality rule used when a request is accepted.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Unsigned widths are load-only; any other code is reported as misaligned.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] byte_off);
    case (funct3)
      F3_B:    access_ok = 1'b1;
      F3_H:    access_ok = ~byte_off[0];
      F3_W:    access_ok = (byte_off == 2'b00);
      F3_BU:   access_ok = ~is_store;
      F3_HU:   access_ok = ~is_store & ~byte_off[0];
      default: access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-bus signals of the load/store unit.
// master = the LSU itself, slave = the core/bus environment around it.
interface load_store_unit_if;
  logic        valid;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    input  valid, mem_write, funct3, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
    output stall, done, rdata, misaligned, bus_err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output valid, mem_write, funct3, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
    input  stall, done, rdata, misaligned, bus_err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/byte-enable placement on the 32-bit bus and
// sign/zero extraction of load data from the returned word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_lanes,
  output logic [31:0] o_rdata_ext
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = i_rdata_word >> {i_byte_off, 3'b000};
  assign w_half_sh = i_rdata_word >> {i_byte_off[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  always_comb begin
    o_be          = 4'b1111;
    o_wdata_lanes = i_wdata;
    if (i_is_store) begin
      case (i_funct3)
        F3_B: begin
          o_be          = 4'b0001 << i_byte_off;
          o_wdata_lanes = {4{i_wdata[7:0]}};
        end
        F3_H: begin
          o_be          = 4'b0011 << {i_byte_off[1], 1'b0};
          o_wdata_lanes = {2{i_wdata[15:0]}};
        end
        default: begin
          o_be          = 4'b1111;
          o_wdata_lanes = i_wdata;
        end
      endcase
    end
  end

  always_comb begin
    o_rdata_ext = i_rdata_word;
    case (i_funct3)
      F3_B:    o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   o_rdata_ext = {24'h000000, w_byte};
      F3_HU:   o_rdata_ext = {16'h0000, w_half};
      default: o_rdata_ext = i_rdata_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: sequences one core memory op onto a
// request/grant/rvalid bus with an optional response timeout.
//
// state | meaning
// IDLE  | waiting for a core request; misaligned ops go straight to RESP
// REQ   | bus_req asserted with stable address/data until bus_gnt
// WAIT  | load granted, waiting for bus_rvalid
// RESP  | one-cycle done pulse with rdata/misaligned/bus_err
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.master  lsu
);

  localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  lsu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_mis;
  logic              r_err;

  logic              w_tmo;
  logic              w_in_req;
  logic              w_in_resp;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_lanes;
  logic [31:0]       w_rdata_ext;

  lsu_align u_align (
    .i_is_store    (r_we),
    .i_funct3      (r_funct3),
    .i_byte_off    (r_addr[1:0]),
    .i_wdata       (r_wdata),
    .i_rdata_word  (lsu.bus_rdata),
    .o_be          (w_be),
    .o_wdata_lanes (w_wdata_lanes),
    .o_rdata_ext   (w_rdata_ext)
  );

  // The counter reads BUS_TIMEOUT-1 in the last permitted cycle, so the
  // abort lands exactly BUS_TIMEOUT cycles after the wait began.
  assign w_tmo = (BUS_TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_mis    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (lsu.valid) begin
            r_we     <= lsu.mem_write;
            r_funct3 <= lsu.funct3;
            r_addr   <= lsu.addr;
            r_wdata  <= lsu.wdata;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            if (access_ok(lsu.mem_write, lsu.funct3, lsu.addr[1:0])) begin
              r_mis   <= 1'b0;
              r_state <= REQ;
            end else begin
              r_mis   <= 1'b1;
              r_state <= RESP;
            end
          end
        end
        REQ: begin
          if (lsu.bus_gnt) begin
            r_cnt   <= '0;
            r_state <= r_we ? RESP : WAIT;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (lsu.bus_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_mis   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_in_req  = (r_state == REQ);
  assign w_in_resp = (r_state == RESP);

  assign lsu.bus_req   = w_in_req;
  assign lsu.bus_we    = w_in_req & r_we;
  assign lsu.bus_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign lsu.bus_be    = w_in_req ? w_be : 4'b0000;
  assign lsu.bus_wdata = (w_in_req & r_we) ? w_wdata_lanes : 32'h0;

  assign lsu.done       = w_in_resp;
  assign lsu.misaligned = w_in_resp & r_mis;
  assign lsu.bus_err    = w_in_resp & r_err;
  assign lsu.rdata      = w_in_resp ? r_rdata : 32'h0;

  // Gated by rst so a core holding valid during reset still sees stall low.
  assign lsu.stall = rst & (((r_state == IDLE) & lsu.valid) | (r_state == REQ) | (r_state == WAIT));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// output each cycle, plus literal pins on the headline scenarios.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit #(.BUS_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit          m_active = 0;
  int          m_t0, m_done, m_req_lo, m_req_hi;
  bit          m_exp_mis, m_exp_err, m_exp_we;
  logic [31:0] m_exp_rdata, m_exp_addr, m_exp_wdata;
  logic [3:0]  m_exp_be;

  logic [31:0] obs_rdata, obs_bus_addr, obs_bus_wdata;
  logic [3:0]  obs_bus_be;
  logic        obs_mis, obs_err, obs_bus_we;
  int          obs_done_cyc, obs_req_cycles, obs_done_cnt = 0;
  int          last_t0;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b1;
      3'b001:  return (a % 2) == 0;
      3'b010:  return (a % 4) == 0;
      3'b100:  return !we;
      3'b101:  return !we && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int v;
    if (!we || f3 == 3'b010) return 4'hF;
    if (f3 == 3'b000) v = 2 ** (a % 4);
    else              v = ((a % 4) >= 2) ? 12 : 3;
    return 4'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int b, h;
    b = wd % 256;
    h = wd % 65536;
    if (f3 == 3'b000) return 32'(b * 32'h01010101);
    if (f3 == 3'b001) return 32'(h * 32'h00010001);
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    longint u, v;
    int off;
    off = a % 4;
    u = longint'(word) / (longint'(1) << (8 * off));
    case (f3)
      3'b000:  begin v = u % 256;   if (v > 127)   v -= 256;   end
      3'b100:  v = u % 256;
      3'b001:  begin v = u % 65536; if (v > 32767) v -= 65536; end
      3'b101:  v = u % 65536;
      default: v = word;
    endcase
    return 32'(v);
  endfunction

  // gd/rd: cycles bus_gnt/bus_rvalid are held off (-1 = never); stray pulses
  // rvalid with junk data in the first REQ cycle.
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word,
                       input int gd, input int rd, input bit stray);
    int t0, gnt_c, rv_c;
    @(posedge clk); #1;
    t0 = cyc; last_t0 = t0;
    gnt_c = -1; rv_c = -1;
    obs_req_cycles = 0;
    m_t0 = t0;
    m_exp_mis = !legal(we, f3, a);
    m_exp_err = 0;
    m_exp_rdata = 0;
    m_exp_we = we;
    m_exp_addr = a - (a % 4);
    m_exp_be = model_be(we, f3, a);
    m_exp_wdata = model_wdata(f3, wd);
    m_req_lo = t0 + 1;
    m_req_hi = t0;
    if (m_exp_mis) begin
      m_done = t0 + 1;
    end else if (gd < 0 || gd >= TMO) begin
      m_req_hi = t0 + TMO;
      m_done = t0 + 1 + TMO;
      m_exp_err = 1;
    end else begin
      gnt_c = t0 + 1 + gd;
      m_req_hi = gnt_c;
      if (we) m_done = gnt_c + 1;
      else if (rd < 0 || rd >= TMO) begin
        m_done = gnt_c + 1 + TMO;
        m_exp_err = 1;
      end else begin
        rv_c = gnt_c + 1 + rd;
        m_done = rv_c + 1;
        m_exp_rdata = model_load(f3, a, word);
      end
    end
    m_active = 1;
    bus.valid = 1; bus.mem_write = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    bus.bus_rdata = word;
    for (int c = t0 + 1; c <= m_done; c++) begin
      @(posedge clk); #1;
      bus.valid = 0;
      bus.bus_gnt = (c == gnt_c);
      bus.bus_rvalid = (c == rv_c) || (stray && c == t0 + 1);
      bus.bus_rdata = (stray && c == t0 + 1) ? 32'hDEAD_BEEF : word;
    end
    @(posedge clk); #1;
    bus.bus_gnt = 0; bus.bus_rvalid = 0;
    m_active = 0;
  endtask

  initial begin : compare
    bit ex_done, ex_req;
    forever begin
      @(negedge clk);
      ex_done = m_active && (cyc == m_done);
      ex_req  = m_active && (cyc >= m_req_lo) && (cyc <= m_req_hi);
      chk("done", bus.done, ex_done);
      chk("stall", bus.stall, m_active && (cyc >= m_t0) && (cyc < m_done));
      chk("misaligned", bus.misaligned, ex_done && m_exp_mis);
      chk("bus_err", bus.bus_err, ex_done && m_exp_err);
      chk("rdata", bus.rdata, ex_done ? m_exp_rdata : 32'h0);
      chk("bus_req", bus.bus_req, ex_req);
      if (ex_req) begin
        chk("bus_addr", bus.bus_addr, m_exp_addr);
        chk("bus_be", bus.bus_be, m_exp_be);
        chk("bus_we", bus.bus_we, m_exp_we);
        if (m_exp_we) chk("bus_wdata", bus.bus_wdata, m_exp_wdata);
      end else begin
        chk("bus_idle", {bus.bus_we, bus.bus_be, bus.bus_addr | bus.bus_wdata}, 37'h0);
      end
      if (bus.done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        obs_rdata = bus.rdata;
        obs_mis = bus.misaligned;
        obs_err = bus.bus_err;
      end
      if (bus.bus_req) begin
        obs_req_cycles++;
        obs_bus_addr = bus.bus_addr;
        obs_bus_be = bus.bus_be;
        obs_bus_we = bus.bus_we;
        obs_bus_wdata = bus.bus_wdata;
      end
    end
  end

  initial begin : stim
    int t0, done_before;
    rst = 1;
    bus.valid = 0; bus.mem_write = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
    bus.bus_gnt = 0; bus.bus_rvalid = 0; bus.bus_rdata = 0;
    #1 rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    do_op(0, 3'b000, 32'h1003, 0, 32'h80FF_FF7F, 0, 0, 0);
    chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    chk("lb_latency", obs_done_cyc - last_t0, 3);
    chk("lb_bus_addr", obs_bus_addr, 32'h1000);

    do_op(1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, 0, 0);
    chk("sh_be", obs_bus_be, 4'b1100);
    chk("sh_wdata", obs_bus_wdata, 32'hBEEF_BEEF);
    chk("sh_we", obs_bus_we, 1);
    chk("sh_latency", obs_done_cyc - last_t0, 2);

    do_op(0, 3'b010, 32'h0006, 0, 0, -1, -1, 0);
    chk("lw_mis_flag", obs_mis, 1);
    chk("lw_mis_latency", obs_done_cyc - last_t0, 1);
    chk("lw_mis_no_req", obs_req_cycles, 0);

    do_op(0, 3'b101, 32'h0002, 0, 32'hABCD_1234, 3, 0, 0);
    chk("lhu_rdata", obs_rdata, 32'h0000_ABCD);
    chk("lhu_req_cycles", obs_req_cycles, 4);

    do_op(0, 3'b010, 32'h0010, 0, 32'h1234_5678, -1, -1, 0);
    chk("tmo_err", obs_err, 1);
    chk("tmo_latency", obs_done_cyc - (last_t0 + 1), 16);
    chk("tmo_rdata", obs_rdata, 0);

    // Reset while a load sits in WAIT; the late rvalid must be ignored.
    @(posedge clk); #1;
    t0 = cyc;
    m_t0 = t0; m_done = t0 + 100; m_req_lo = t0 + 1; m_req_hi = t0 + 1;
    m_exp_mis = 0; m_exp_err = 0; m_exp_rdata = 0; m_exp_we = 0;
    m_exp_addr = 32'h40; m_exp_be = 4'hF; m_exp_wdata = 0;
    m_active = 1;
    bus.valid = 1; bus.mem_write = 0; bus.funct3 = 3'b010; bus.addr = 32'h40;
    @(posedge clk); #1; bus.valid = 0; bus.bus_gnt = 1;
    @(posedge clk); #1; bus.bus_gnt = 0;
    @(posedge clk); #2; rst = 0; m_active = 0;
    done_before = obs_done_cnt;
    @(posedge clk); #1; rst = 1; bus.bus_rvalid = 1; bus.bus_rdata = 32'h5555_5555;
    @(posedge clk); #1; bus.bus_rvalid = 0;
    repeat (4) @(posedge clk);
    chk("rst_no_done", obs_done_cnt, done_before);

    do_op(1, 3'b000, 32'h3001, 32'h1234_5678, 0, 0, 0, 0);
    chk("sb_be", obs_bus_be, 4'b0010);
    chk("sb_wdata", obs_bus_wdata, 32'h7878_7878);
    chk("sb_latency", obs_done_cyc - last_t0, 2);

    do_op(0, 3'b001, 32'h5002, 0, 32'h8001_0000, 2, 1, 1);
    chk("lh_rdata", obs_rdata, 32'hFFFF_8001);
    do_op(0, 3'b100, 32'h0007, 0, 32'h8000_0000, 0, 2, 0);
    chk("lbu_rdata", obs_rdata, 32'h0000_0080);
    do_op(1, 3'b010, 32'h0008, 32'hCAFE_F00D, 0, 2, 0, 0);
    chk("sw_be", obs_bus_be, 4'hF);

    do_op(0, 3'b010, 32'h000C, 0, 32'h1122_3344, TMO - 1, TMO - 1, 0);
    chk("edge_latency", obs_done_cyc - last_t0, 33);
    chk("edge_rdata", obs_rdata, 32'h1122_3344);
    chk("edge_err", obs_err, 0);

    do_op(0, 3'b011, 32'h0000, 0, 0, 0, 0, 0);
    do_op(0, 3'b001, 32'h0001, 0, 0, 0, 0, 0);
    do_op(1, 3'b100, 32'h0000, 32'h11, 0, 0, 0, 0);
    do_op(0, 3'b000, 32'h0020, 0, 32'h0, 0, -1, 0);
    chk("rv_tmo_latency", obs_done_cyc - last_t0, 18);
    do_op(1, 3'b001, 32'h0100, 32'h0000_1357, 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
